// File: rtl/inst_fetch_bridge.sv
// rtl/inst_fetch_bridge.sv - one-entry line-buffered instruction fetch bridge
module inst_fetch_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i,
    output logic        bus_err_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Counter compares against TIMEOUT-1; 8 bits covers the 2..255 range.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [29:0] r_req_tag;
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic        r_bus_req;
    logic [31:0] r_bus_addr;
    logic        r_bus_err;

    logic        w_hit;
    logic        w_issue;
    logic        w_ack_fill;
    logic        w_timeout;

    // Hit ignores the byte offset: the buffer holds one aligned word.
    assign w_hit      = if_ce_i & r_buf_valid & (r_buf_tag == if_addr_i[31:2]);
    assign if_data_o  = w_hit ? r_buf_data : 32'h0;
    assign stallreq_o = if_ce_i & ~w_hit;
    assign bus_req_o  = r_bus_req;
    assign bus_addr_o = r_bus_addr;
    assign bus_err_o  = r_bus_err;

    // Next-state and event decode; ack beats timeout when both land together.
    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_ack_fill = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_ce_i && !w_hit) begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_ack_i) begin
                    w_ack_fill = 1'b1;
                    w_next     = S_IDLE;
                end else if (r_cnt == TIMEOUT_M1) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request, counter and line-buffer updates driven by the decoded events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_req_tag   <= 30'd0;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 30'd0;
            r_buf_data  <= 32'h0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_issue) begin
                r_bus_req  <= 1'b1;
                r_bus_addr <= {if_addr_i[31:2], 2'b00};
                r_req_tag  <= if_addr_i[31:2];
                r_cnt      <= 8'd0;
            end else if (w_ack_fill) begin
                r_buf_data  <= bus_data_i;
                r_buf_tag   <= r_req_tag;
                r_buf_valid <= 1'b1;
                r_bus_req   <= 1'b0;
            end else if (w_timeout) begin
                // Abandoned fetch fills a NOP so the core can proceed.
                r_buf_data  <= 32'h0;
                r_buf_tag   <= r_req_tag;
                r_buf_valid <= 1'b1;
                r_bus_req   <= 1'b0;
                r_bus_err   <= 1'b1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
